mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multi-cycle core's unified instruction/data memory port. It accepts one read or write request at a time over a req/ready handshake and inserts a fixed, parameterised number of wait states. It completes the access against an internal word-organised array. It sits between the core's address/write-data path, driven by the main controller's address-select and memory-write decode, and the instruction/data registers.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — number of 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, 2 — wait states inserted between request acceptance and access; 0–15.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `req`  in  1  — request valid; sampled only in IDLE.
- `we`  in  1  — 1 = write, 0 = read; sampled with `req`.
- `addr`  in  32  — byte address; sampled with `req`.
- `wdata`  in  32  — write data; sampled with `req`.
- `rdata`  out  32  — read data; valid while `ready`=1 and holds until the next completed read.
- `ready`  out  1  — one-cycle completion pulse.
- `busy`  out  1  — high from acceptance until completion, inclusive of the ACCESS cycle.
- `err`  out  1  — misaligned-access flag, coincident with `ready`.

## Operation
- FSM states: IDLE, WAIT, ACCESS.
- **IDLE, `req`=0:** remain in IDLE.
- **IDLE, `req`=1:** latch `we`, `addr`, `wdata`; load the 4-bit counter with `WAIT_CYCLES`.
  - If `WAIT_CYCLES`=0, go to ACCESS.
  - Otherwise go to WAIT.
- **WAIT:** decrement the counter each cycle; go to ACCESS in the cycle the counter reaches 1.
- **ACCESS:**
  - Word index is latched `addr[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap modulo `DEPTH_WORDS`×4.
  - Write: `mem[index]` ← latched `wdata` at the clock edge ending ACCESS; `rdata` is unchanged.
  - Read: `rdata` ← `mem[index]`, registered; visible in the ACCESS cycle (combinational read of the array, registered onto `rdata` at ACCESS entry).
  - `ready`=1 for exactly this cycle; next state is IDLE.
- `req`, `we`, `addr`, `wdata` are ignored outside IDLE. Inputs changing mid-transaction have no effect.
- Array contents are not reset and persist across `reset`. Initial contents are undefined; the bench preloads them by hierarchical access.

## Timing
- Reset values: state IDLE, `rdata`=0, `ready`=0, `busy`=0, `err`=0, counter=0.
- If `req` is sampled high at edge T0, `busy` goes high after T0 and `ready` is high during cycle T0+`WAIT_CYCLES`+1.
- Throughput: one transaction per `WAIT_CYCLES`+2 cycles. The cycle after `ready` is always IDLE, and `req` held high there is accepted.
- Reset asserted mid-transaction aborts immediately. No write occurs if reset is asserted before the ACCESS edge, and no `ready` pulse follows.
- Read-after-write to the same word returns the new data.
- `busy` and `ready` are both high in the ACCESS cycle; `busy` falls with `ready`.

## Configuration
- `MEM_RESP_ALIGN_CHECK_EN` defined:
  - In ACCESS, latched `addr[1:0]`≠0 sets `err`=1 with `ready`.
  - A misaligned write is suppressed.
  - A misaligned read leaves `rdata` unchanged.
- Undefined:
  - `addr[1:0]` is ignored and the access proceeds on the containing word.
  - `err` is tied to 0.

## Test plan
- **Read with `WAIT_CYCLES`=2:** preload `mem[5]`=32'hDEADBEEF; pulse `req` with `we`=0, `addr`=32'h14 → `ready` 3 cycles after acceptance, `rdata`=32'hDEADBEEF, `busy` high for 3 cycles.
- **Write then read:** write 32'h12345678 to `addr` 32'h08, then read 32'h08 → second `ready` returns 32'h12345678. Back-to-back with `req` held high gives a 4-cycle period.
- **`WAIT_CYCLES`=0 and wrap:** with `DEPTH_WORDS`=16, read `addr` 32'h44 → `ready` 1 cycle after acceptance, data equals `mem[1]`.
- **Ignored requests:** toggle `req` and `addr` during WAIT → single `ready`, and the result reflects the originally latched address.
- **Reset mid-write:** assert `reset` during WAIT of a write to 32'h0C → no `ready`, `mem[3]` unchanged, all outputs 0.
- **With `MEM_RESP_ALIGN_CHECK_EN`:** write to `addr` 32'h0A → `err`=1 with `ready`, `mem[2]` unchanged. Without the macro, the same write updates `mem[2]` and `err`=0.

Source files
------------

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: req/ready handshake, fixed wait states, word array.
// Optional feature macro MEM_RESP_ALIGN_CHECK_EN flags misaligned accesses on err and suppresses them.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            src_we;
  logic [AW+1:0]   src_addr;
  logic            src_mis;
  logic            q_mis;
  logic            go_access;

  // With zero wait states ACCESS is entered straight from IDLE, so decode from the live inputs there.
  always_comb begin
    src_we   = we_q;
    src_addr = addr_q;
    if (state == IDLE) begin
      src_we   = we;
      src_addr = addr[AW+1:0];
    end
  end

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign src_mis = |src_addr[1:0];
  assign q_mis   = |addr_q[1:0];
`else
  assign src_mis = 1'b0;
  assign q_mis   = 1'b0;
`endif

  assign go_access = ((state == IDLE) && req && (WAIT_LD == 4'd0)) ||
                     ((state == WAIT) && (cnt <= 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            cnt     <= WAIT_LD;
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT:    cnt <= cnt - 4'd1;
        ACCESS: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // ready/err/rdata are registered on the edge entering ACCESS so they line up with that cycle.
      if (go_access) begin
        state <= ACCESS;
        ready <= 1'b1;
        err   <= src_mis;
        if (!src_we && !src_mis) rdata <= mem[src_addr[AW+1:2]];
      end
    end
  end

  // No reset here: contents persist, and a reset before the ACCESS edge leaves state != ACCESS.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && !q_mis) mem[addr_q[AW+1:2]] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table-driven transactions, scoreboard checked on ready, plus corner sequences.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, ready0, busy0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, ready1, busy1, err1;
  logic [31:0] addr1, wdata1, rdata1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct { logic [31:0] rd; logic e; } exp_t;
  typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic [31:0] rd; logic e; } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];
  vec_t tbl[6];

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

  mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest expectation pushed at request time.
  always @(negedge clk) begin
    exp_t x;
    if (ready0) begin
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_ready got ready=1 expected none");
      end else begin
        x = sb0.pop_front();
        chk("u0_rdata", rdata0, x.rd);
        chk("u0_err", {31'b0, err0}, {31'b0, x.e});
      end
    end
    if (ready1) begin
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_ready got ready=1 expected none");
      end else begin
        x = sb1.pop_front();
        chk("u1_rdata", rdata1, x.rd);
        chk("u1_err", {31'b0, err1}, {31'b0, x.e});
      end
    end
  end

  task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] rd, input logic e);
    int n;
    logic got, b, r;
    exp_t x;
    string p;
    p = (sel == 0) ? "u0" : "u1";
    x.rd = rd; x.e = e;
    @(negedge clk);
    if (sel == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; sb0.push_back(x); end
    else          begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; sb1.push_back(x); end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      b = (sel == 0) ? busy0 : busy1;
      r = (sel == 0) ? ready0 : ready1;
      chk({p, "_busy_during"}, {31'b0, b}, 32'd1);
      if (r) got = 1;
    end
    chk({p, "_latency"}, n, (sel == 0) ? 32'd3 : 32'd1);
    @(negedge clk);
    b = (sel == 0) ? busy0 : busy1;
    chk({p, "_busy_after"}, {31'b0, b}, 32'd0);
  endtask

  initial begin : timeout
    #200000;
    errors++;
    $display("FAIL global_timeout got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n, t1, t2, cnt_rdy;
    exp_t x;
    reset = 1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tbl[0] = '{1'b0, 32'h14,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h08,   32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 32'h08,   32'h0,        32'h12345678, 1'b0};
    tbl[3] = '{1'b1, 32'h1010, 32'hAAAA5555, 32'h12345678, 1'b0};
    tbl[4] = '{1'b0, 32'h10,   32'h0,        32'hAAAA5555, 1'b0};
    tbl[5] = '{1'b0, 32'h15,   32'h0,        ALN ? 32'hAAAA5555 : 32'hDEADBEEF, ALN};

    u0.mem[5] = 32'hDEADBEEF;
    u0.mem[3] = 32'h33333333;
    u1.mem[1] = 32'hCAFE0001;

    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_ready0", {31'b0, ready0}, 32'd0);
    chk("rst_busy0",  {31'b0, busy0},  32'd0);
    chk("rst_err0",   {31'b0, err0},   32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_busy1",  {31'b0, busy1},  32'd0);

    for (int i = 0; i < 6; i++) txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].e);

    // Zero wait states with wrap: 0x44 and 0x48 alias words 1 and 2 of a 16-word array.
    txn(1, 1'b0, 32'h44, 32'h0,        32'hCAFE0001, 1'b0);
    txn(1, 1'b1, 32'h48, 32'h77778888, 32'hCAFE0001, 1'b0);
    txn(1, 1'b0, 32'h08, 32'h0,        32'h77778888, 1'b0);

    // Back-to-back write then read with req held high.
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h0BADF00D;
    x.rd = ALN ? 32'hAAAA5555 : 32'hDEADBEEF; x.e = 1'b0; sb0.push_back(x);
    n = 0;
    do begin @(negedge clk); n++; end while (!ready0 && n < 20);
    t1 = cyc;
    we0 = 0;
    x.rd = 32'h0BADF00D; x.e = 1'b0; sb0.push_back(x);
    n = 0;
    do begin @(negedge clk); n++; end while (!ready0 && n < 20);
    t2 = cyc;
    req0 = 0;
    chk("b2b_period", t2 - t1, 32'd4);

    // Requests and address changes during WAIT are ignored.
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h14;
    x.rd = 32'hDEADBEEF; x.e = 1'b0; sb0.push_back(x);
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h08;
    @(posedge clk); #1;
    req0 = 0; addr0 = 32'h20;
    cnt_rdy = 0;
    repeat (8) begin @(negedge clk); if (ready0) cnt_rdy++; end
    chk("ignored_ready_count", cnt_rdy, 32'd1);
    chk("ignored_mem2", u0.mem[2], 32'h12345678);

    // Reset during WAIT of a write aborts it.
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'h0C; wdata0 = 32'hFFFF0000;
    @(posedge clk); #1;
    req0 = 0;
    @(negedge clk);
    reset = 1;
    #1;
    chk("rstmid_rdata", rdata0, 32'd0);
    chk("rstmid_ready", {31'b0, ready0}, 32'd0);
    chk("rstmid_busy",  {31'b0, busy0},  32'd0);
    chk("rstmid_err",   {31'b0, err0},   32'd0);
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    chk("rstmid_mem3", u0.mem[3], 32'h33333333);

    // Misaligned write: suppressed and flagged only with the alignment check built in.
    txn(0, 1'b1, 32'h0A, 32'h5A5A5A5A, 32'd0, ALN);
    chk("misaligned_mem2", u0.mem[2], ALN ? 32'h12345678 : 32'h5A5A5A5A);

    repeat (3) @(negedge clk);
    chk("sb0_drained", sb0.size(), 32'd0);
    chk("sb1_drained", sb1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
